// File: rtl/rgbw_pkg.sv
// Shared definitions for the SPI frame dispatcher.
//   state_e   : frame parser states (HUNT, PAYLOAD, MODE, CHECK)
//   SYNC_BYTE : default frame start byte
package rgbw_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    MODE    = 2'd2,
    CHECK   = 2'd3
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h55;

endpackage

// File: rtl/rdy_edge_sync.sv
// Two-flop synchroniser for the asynchronous byte-ready strobe, followed by a
// rising-edge detector. Every flop advances only on clk_en ticks.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-low reset
//   clk_en  in  tick enable
//   rdy_in  in  asynchronous byte-ready strobe
//   evt     out one byte event, valid on an enabled tick (combinational)
module rdy_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic rdy_in,
  output logic evt
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = sync1_q;
    sync2_d = sync2_q;
    prev_d  = prev_q;
    if (clk_en) begin
      sync1_d = rdy_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // The event is gated by clk_en so that it lasts exactly one enabled tick
  // no matter how many disabled clocks sit between ticks.
  assign evt = clk_en & sync2_q & ~prev_q;

endmodule

// File: rtl/spi_frame_dispatcher.sv
// Parses framed bytes arriving from an SPI receiver and dispatches them to
// channel and mode registers. Frame: SYNC, NCH payload bytes (channel 0
// first), MODE, then an XOR checksum byte when CHK_EN=1. Payload is collected
// in shadow registers and copied to the outputs in one step on commit, so the
// outputs never show a partial frame.
// Ports:
//   clk         in  system clock
//   reset       in  synchronous, active-low reset
//   clk_en      in  tick enable; all state advances only on enabled ticks
//   rx_data     in  received byte, stable while rx_rdy is high
//   rx_rdy      in  asynchronous byte-ready strobe
//   ch_out      out channel registers, channel k at [8k+7:8k]
//   mode_out    out mode register
//   frame_valid out one-tick pulse when a good frame is committed
//   frame_err   out one-tick pulse on checksum, timeout or index error
module spi_frame_dispatcher
  import rgbw_pkg::*;
#(
  parameter int         NCH     = 6,
  parameter logic [7:0] SYNC    = SYNC_BYTE,
  parameter int         TIMEOUT = 255,
  parameter bit         CHK_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic [7:0]       rx_data,
  input  logic             rx_rdy,
  output logic [NCH*8-1:0] ch_out,
  output logic [7:0]       mode_out,
  output logic             frame_valid,
  output logic             frame_err
);

  localparam int IDX_W = $clog2(NCH + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         chk_q, chk_d;
  logic [15:0]        gap_q, gap_d;
  logic [7:0]         shadow_q [NCH];
  logic [7:0]         shadow_d [NCH];
  logic [7:0]         mode_sh_q, mode_sh_d;
  logic [7:0]         ch_q [NCH];
  logic [7:0]         ch_d [NCH];
  logic [7:0]         mode_q, mode_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic               byte_evt;
  logic               idx_bad;
  logic               idx_last;
  logic [15:0]        gap_inc;
  logic               timeout_hit;

  rdy_edge_sync u_rdy_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .rdy_in (rx_rdy),
    .evt    (byte_evt)
  );

  assign idx_bad  = (state_q == PAYLOAD) && (idx_q > IDX_W'(NCH - 1));
  assign idx_last = (idx_q == IDX_W'(NCH - 1));
  assign gap_inc  = gap_q + 16'd1;
  // A byte event on the same tick takes priority over the timeout.
  assign timeout_hit = (state_q != HUNT) && !byte_evt && (gap_inc == 16'(TIMEOUT));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clk_en) begin
      if (idx_bad) begin
        state_d = HUNT;
      end else if (byte_evt) begin
        case (state_q)
          HUNT:    if (rx_data == SYNC) state_d = PAYLOAD;
          PAYLOAD: if (idx_last) state_d = MODE;
          MODE:    state_d = CHK_EN ? CHECK : HUNT;
          CHECK:   state_d = HUNT;
          default: state_d = HUNT;
        endcase
      end else if (timeout_hit) begin
        state_d = HUNT;
      end
    end
  end

  // Datapath and output logic
  always_comb begin
    idx_d     = idx_q;
    chk_d     = chk_q;
    gap_d     = gap_q;
    mode_sh_d = mode_sh_q;
    mode_d    = mode_q;
    valid_d   = valid_q;
    err_d     = err_q;
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = shadow_q[i];
      ch_d[i]     = ch_q[i];
    end

    if (clk_en) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
      gap_d   = (state_q == HUNT) ? 16'd0 : gap_inc;

      if (idx_bad) begin
        err_d = 1'b1;
        gap_d = 16'd0;
      end else if (byte_evt) begin
        gap_d = 16'd0;
        case (state_q)
          HUNT: begin
            if (rx_data == SYNC) begin
              idx_d = '0;
              chk_d = 8'h00;
            end
          end
          PAYLOAD: begin
            for (int i = 0; i < NCH; i++) begin
              if (idx_q == IDX_W'(i)) shadow_d[i] = rx_data;
            end
            idx_d = idx_q + IDX_W'(1);
            chk_d = chk_q ^ rx_data;
          end
          MODE: begin
            mode_sh_d = rx_data;
            chk_d     = chk_q ^ rx_data;
            if (!CHK_EN) begin
              for (int i = 0; i < NCH; i++) ch_d[i] = shadow_q[i];
              mode_d  = rx_data;
              valid_d = 1'b1;
            end
          end
          CHECK: begin
            if (rx_data == chk_q) begin
              for (int i = 0; i < NCH; i++) ch_d[i] = shadow_q[i];
              mode_d  = mode_sh_q;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (timeout_hit) begin
        err_d = 1'b1;
        gap_d = 16'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q     <= '0;
      chk_q     <= 8'h00;
      gap_q     <= 16'd0;
      mode_sh_q <= 8'h00;
      mode_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= 8'h00;
        ch_q[i]     <= 8'h00;
      end
    end else begin
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      gap_q     <= gap_d;
      mode_sh_q <= mode_sh_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= shadow_d[i];
        ch_q[i]     <= ch_d[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch_pack
      assign ch_out[8*gi +: 8] = ch_q[gi];
    end
  endgenerate

  assign mode_out    = mode_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_spi_frame_dispatcher.sv
module tb_spi_frame_dispatcher;

  localparam int NCH = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             clk_en;
  logic [7:0]       rx_data;
  logic             rx_rdy;
  logic [NCH*8-1:0] ch_out;
  logic [7:0]       mode_out;
  logic             frame_valid;
  logic             frame_err;

  int checks = 0;
  int errors = 0;
  int fv_cnt;
  int fe_cnt;

  spi_frame_dispatcher #(
    .NCH     (NCH),
    .SYNC    (8'h55),
    .TIMEOUT (4),
    .CHK_EN  (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .ch_out      (ch_out),
    .mode_out    (mode_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte takes effect on the last edge of this task; outputs are
  // sampled 1 time unit after it.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    tick();
    rx_rdy = 1'b0;
    tick();
  endtask

  task automatic send_seq(input logic [7:0] bytes [], input int n);
    for (int i = 0; i < n; i++) send_byte(bytes[i]);
  endtask

  logic [7:0] fr [];

  initial begin
    reset   = 1'b0;
    clk_en  = 1'b0;
    rx_data = 8'h00;
    rx_rdy  = 1'b0;

    // Reset with clk_en low still takes effect
    tick(); tick(); tick();
    check("reset_ch_out", 64'(ch_out), 64'h0);
    check("reset_mode", 64'(mode_out), 64'h0);
    check("reset_fv", 64'(frame_valid), 64'h0);
    check("reset_fe", 64'(frame_err), 64'h0);
    reset  = 1'b1;
    clk_en = 1'b1;
    tick();
    $display("step reset done");

    // Good frame
    fr = '{8'h55, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h07};
    send_seq(fr, 8);
    check("atomic_before_chk", 64'(ch_out), 64'h0);
    send_byte(8'h77);
    check("good_fv", 64'(frame_valid), 64'h1);
    check("good_fe", 64'(frame_err), 64'h0);
    check("good_ch", 64'(ch_out), 64'h0000_6050_4030_2010);
    check("good_mode", 64'(mode_out), 64'h07);
    tick();
    check("good_fv_pulse_end", 64'(frame_valid), 64'h0);
    $display("step good frame ch_out=%h mode=%h", ch_out, mode_out);

    // Bad checksum (correct would be 0F)
    fr = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h10};
    send_seq(fr, 9);
    check("badchk_fe", 64'(frame_err), 64'h1);
    check("badchk_fv", 64'(frame_valid), 64'h0);
    check("badchk_ch_hold", 64'(ch_out), 64'h0000_6050_4030_2010);
    check("badchk_mode_hold", 64'(mode_out), 64'h07);
    tick();
    check("badchk_fe_pulse_end", 64'(frame_err), 64'h0);
    $display("step bad checksum fe observed");

    // Timeout after 55,AA
    send_byte(8'h55);
    send_byte(8'hAA);
    tick(); tick(); tick();
    check("timeout_not_yet", 64'(frame_err), 64'h0);
    tick();
    check("timeout_fe", 64'(frame_err), 64'h1);
    tick();
    check("timeout_fe_end", 64'(frame_err), 64'h0);
    fv_cnt = 0;
    fe_cnt = 0;
    rx_data = 8'h11; rx_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin tick(); fv_cnt += int'(frame_valid); fe_cnt += int'(frame_err); end
    rx_rdy = 1'b0;
    for (int i = 0; i < 1; i++) begin tick(); fv_cnt += int'(frame_valid); fe_cnt += int'(frame_err); end
    rx_data = 8'h22; rx_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin tick(); fv_cnt += int'(frame_valid); fe_cnt += int'(frame_err); end
    rx_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); fv_cnt += int'(frame_valid); fe_cnt += int'(frame_err); end
    check("nosync_fv_cnt", 64'(fv_cnt), 64'd0);
    check("nosync_fe_cnt", 64'(fe_cnt), 64'd0);
    check("nosync_ch_hold", 64'(ch_out), 64'h0000_6050_4030_2010);
    $display("step timeout and no-sync bytes done");

    // Leading garbage, SYNC value inside payload
    fr = '{8'h00, 8'hFF, 8'h55, 8'hA1, 8'h55, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'h3C, 8'h88};
    send_seq(fr, 11);
    check("garbage_fv", 64'(frame_valid), 64'h1);
    check("garbage_ch", 64'(ch_out), 64'h0000_E5D4_C3B2_55A1);
    check("garbage_mode", 64'(mode_out), 64'h3C);
    tick();
    $display("step garbage frame ch_out=%h", ch_out);

    // Reset mid-frame, then a full frame
    fr = '{8'h55, 8'h01, 8'h02};
    send_seq(fr, 3);
    reset = 1'b0;
    tick();
    check("midreset_ch", 64'(ch_out), 64'h0);
    check("midreset_mode", 64'(mode_out), 64'h0);
    reset = 1'b1;
    tick();
    fr = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h0F};
    send_seq(fr, 9);
    check("after_reset_fv", 64'(frame_valid), 64'h1);
    check("after_reset_ch", 64'(ch_out), 64'h0000_0605_0403_0201);
    check("after_reset_mode", 64'(mode_out), 64'h08);
    tick();
    $display("step mid-frame reset done");

    // rx_rdy held high for 10 ticks on the final byte
    fr = '{8'h55, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h22};
    send_seq(fr, 8);
    fv_cnt = 0;
    fe_cnt = 0;
    rx_data = 8'h55;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); fv_cnt += int'(frame_valid); fe_cnt += int'(frame_err); end
    rx_rdy = 1'b0;
    for (int i = 0; i < 15; i++) begin tick(); fv_cnt += int'(frame_valid); fe_cnt += int'(frame_err); end
    check("held_rdy_fv_cnt", 64'(fv_cnt), 64'd1);
    check("held_rdy_fe_cnt", 64'(fe_cnt), 64'd0);
    check("held_rdy_ch", 64'(ch_out), 64'h0000_6655_4433_2211);
    check("held_rdy_mode", 64'(mode_out), 64'h22);
    $display("step held rx_rdy fv_cnt=%0d", fv_cnt);

    // clk_en low: a full frame goes unseen
    clk_en = 1'b0;
    fv_cnt = 0;
    fe_cnt = 0;
    fr = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h0F};
    for (int i = 0; i < 9; i++) begin
      send_byte(fr[i]);
      fv_cnt += int'(frame_valid);
      fe_cnt += int'(frame_err);
    end
    clk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(); fv_cnt += int'(frame_valid); fe_cnt += int'(frame_err); end
    check("noen_fv_cnt", 64'(fv_cnt), 64'd0);
    check("noen_fe_cnt", 64'(fe_cnt), 64'd0);
    check("noen_ch_hold", 64'(ch_out), 64'h0000_6655_4433_2211);
    check("noen_mode_hold", 64'(mode_out), 64'h22);
    $display("step clk_en low done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_dispatcher.md
SPI_FRAME_DISPATCHER -- requirements
Module: spi_frame_dispatcher

Interface
REQ-001 SHALL have parameter NCH, default 6, number of 8-bit payload channels (range 1..15).
REQ-002 SHALL have parameter SYNC, default 8'h55, frame start byte.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum inter-byte gap in enable ticks (range 1..65535).
REQ-004 SHALL have parameter CHK_EN, default 1, which appends a checksum byte when 1.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-007 clk_en  in  1  tick enable; all state advances only on clk edges where clk_en=1.
REQ-008 rx_data  in  8  received byte, stable while rx_rdy is high.
REQ-009 rx_rdy  in  1  byte-ready strobe, asynchronous to clk_en ticks.
REQ-010 ch_out  out  NCH*8  channel registers; channel k occupies bits [8k+7:8k].
REQ-011 mode_out  out  8  mode register.
REQ-012 frame_valid  out  1  one-tick pulse when a good frame is committed.
REQ-013 frame_err  out  1  one-tick pulse on a checksum, timeout or overflow error.

Function
REQ-014 rx_rdy SHALL pass through a 2-flop synchroniser on enabled ticks; a byte event occurs on the tick where the synchronised value is 1 and its previous value was 0.
REQ-015 On a byte event, rx_data SHALL be captured on that same tick.
REQ-016 The frame SHALL be: SYNC, then NCH payload bytes (channel 0 first), then MODE, then CHK if CHK_EN=1.
REQ-017 The FSM SHALL have states HUNT, PAYLOAD, MODE and CHECK; the reset state is HUNT.
REQ-018 HUNT: a byte equal to SYNC SHALL go to PAYLOAD, clear idx and the running checksum; any other byte SHALL stay in HUNT with no error.
REQ-019 PAYLOAD: each byte SHALL go into the shadow register at idx, idx increments, and the byte is XORed into the checksum; after byte NCH-1 the FSM goes to MODE.
REQ-020 A SYNC-valued byte inside PAYLOAD, MODE or CHECK SHALL be treated as data, with no resync.
REQ-021 MODE: the byte SHALL go into the mode shadow register and be XORed into the checksum; the FSM then goes to CHECK if CHK_EN=1, else commits and returns to HUNT.
REQ-022 CHECK: if the byte equals the running XOR, the block SHALL commit; otherwise it SHALL pulse frame_err with no commit; either way it returns to HUNT.
REQ-023 Commit SHALL copy all shadows to ch_out and mode_out atomically on the tick after the final byte event, with frame_valid high on that same tick.
REQ-024 Outputs SHALL never show a partially updated frame.
REQ-025 Timeout: outside HUNT, a 16-bit gap counter SHALL increment each enabled tick and clear on each byte event.
REQ-026 When the gap counter reaches TIMEOUT, the FSM SHALL go to HUNT and pulse frame_err, and the shadows are discarded.
REQ-027 A byte event on the same tick the gap counter reaches TIMEOUT SHALL win: the byte is processed, the counter clears and no error is raised.
REQ-028 The idx counter SHALL be ceil(log2(NCH+1)) bits; an idx beyond NCH-1 (unreachable) SHALL force HUNT and pulse frame_err.
REQ-029 frame_valid and frame_err SHALL never be high on the same tick, and each SHALL be high for exactly one enabled tick.
REQ-030 Outputs SHALL hold their values indefinitely between commits.

Reset
REQ-031 With reset=0 on a clk edge, independent of clk_en, the block SHALL clear ch_out, mode_out, all shadows, idx, checksum, gap counter and synchroniser flops to 0, clear frame_valid and frame_err, and set the state to HUNT.
REQ-032 A reset in the middle of a frame SHALL discard the partial frame; the next frame needs a fresh SYNC.

Structure
REQ-033 The shared package rgbw_pkg SHALL hold the FSM state enum (HUNT, PAYLOAD, MODE, CHECK) and the default constant SYNC_BYTE=8'h55.
REQ-034 A single sub-module rdy_edge_sync SHALL hold the 2-flop synchroniser and the rising-edge detector, gated by clk_en.

Verification
REQ-035 Scenario: NCH=6, CHK_EN=1; send 55,10,20,30,40,50,60,07,CHK=0x07^XOR(10..60) -> ch_out={60,50,40,30,20,10}, mode_out=07, one frame_valid pulse.
REQ-036 Scenario: same frame with CHK off by one -> frame_err pulse; outputs keep their previous values.
REQ-037 Scenario: TIMEOUT=4; send 55,AA, then wait 4 enabled ticks -> frame_err and HUNT; next bytes 11,22 without SYNC -> no output change.
REQ-038 Scenario: leading garbage 00,FF,55 followed by a valid frame whose payload contains 55 -> one commit, with 55 stored in its channel.
REQ-039 Scenario: reset=0 asserted after byte 3 of a frame, then a complete valid frame -> all outputs 0 after reset, then the new frame committed.
REQ-040 Scenario: rx_rdy held high across 10 ticks -> exactly one byte event; clk_en=0 throughout -> no state change.
